// File: rtl/clock_disp_pkg.sv
// Shared types, segment encoding and parameter checks for the multiplexed clock display.
package clock_disp_pkg;

    // Active-low segments, all dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Current time as six BCD digits, hours first.
    typedef struct packed {
        logic [3:0] hr_t;
        logic [3:0] hr_o;
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
    } time_bcd_t;

    // BCD digit to active-low segment pattern; anything outside 0..9 shows dark.
    function automatic logic [6:0] seg7_of(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0001000;
            4'd1:    seg = 7'b1101110;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b1000010;
            4'd4:    seg = 7'b1100100;
            4'd5:    seg = 7'b1000001;
            4'd6:    seg = 7'b0000001;
            4'd7:    seg = 7'b1101010;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b1000000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Only 4-digit (MM:SS / HH:MM) and 6-digit (HH:MM:SS) panels are supported.
    function automatic bit digits_legal(input int unsigned d);
        return (d == 4) || (d == 6);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Modulo-MOD time field (seconds, minutes or hours) presented as two BCD digits.
// inc and carry_in add together, so a simultaneous adjust and carry advance by two.
module bcd_mod_counter #(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       res,
    input  logic       inc,
    input  logic       carry_in,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    // Wide enough to hold MOD-1 plus two increments before the wrap.
    localparam int unsigned W = $clog2(MOD + 2);

    logic [W-1:0] val_q;
    logic [W-1:0] sum;

    // Next value: add both increment sources and fold back into 0..MOD-1.
    always_comb begin
        sum = val_q + W'(inc) + W'(carry_in);
        if (sum >= W'(MOD)) begin
            sum = sum - W'(MOD);
        end
    end

    // Only a carry arriving at the top value ripples onward; manual adjusts never do.
    assign carry_out = carry_in && (val_q == W'(MOD - 1));

    // Field register; clear wins over counting.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            val_q <= '0;
        end else if (clr) begin
            val_q <= '0;
        end else begin
            val_q <= sum;
        end
    end

    assign tens = 4'(val_q / W'(10));
    assign ones = 4'(val_q % W'(10));

endmodule

// File: rtl/mux_clock_display.sv
// Real-time clock with run/set controls driving a multiplexed 7-segment display.
// Everything runs on CLOCK_50; scan and 1 Hz timing come from clock enables.
module mux_clock_display
    import clock_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              res,
    input  logic              run,
    input  logic              mode,
    input  logic              inc_min,
    input  logic              inc_hr,
    output logic [6:0]        catodes,
    output logic [DIGITS-1:0] digits,
    output logic              secondsPoint,
    output logic              tick_1hz,
    output logic [23:0]       time_bcd
);

    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SEC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    if (!digits_legal(DIGITS)) begin : g_bad_digits
        $error("mux_clock_display: DIGITS must be 4 or 6");
    end
    if ((CLK_HZ % SCAN_HZ) != 0) begin : g_bad_scan
        $error("mux_clock_display: CLK_HZ must be a multiple of SCAN_HZ");
    end

    logic [SCAN_W-1:0] scan_cnt_q;
    logic              scan_en;
    logic [SEC_W-1:0]  sec_cnt_q;
    logic              min_q;
    logic              hr_q;
    logic              min_edge;
    logic              hr_edge;
    logic              sec_step;
    logic              sec_carry;
    logic              min_carry;
    logic              hr_carry_unused;
    logic [2:0]        idx_q;
    logic [2:0]        pos;
    logic [3:0]        nib;
    logic [6:0]        seg;
    time_bcd_t         now;

    assign scan_en  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign tick_1hz = (sec_cnt_q == SEC_W'(CLK_HZ - 1));

    // Digit-step prescaler.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            scan_cnt_q <= '0;
        end else if (scan_en) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
    end

    // One-second prescaler.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            sec_cnt_q <= '0;
        end else if (tick_1hz) begin
            sec_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_q + SEC_W'(1);
        end
    end

    // Seconds point: rises halfway through the second, falls on the 1 Hz wrap.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            secondsPoint <= 1'b0;
        end else if (tick_1hz) begin
            secondsPoint <= 1'b0;
        end else if (sec_cnt_q == SEC_W'(CLK_HZ / 2 - 1)) begin
            secondsPoint <= 1'b1;
        end
    end

    // Previous levels of the adjust buttons for rising-edge detection.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            min_q <= 1'b0;
            hr_q  <= 1'b0;
        end else begin
            min_q <= inc_min;
            hr_q  <= inc_hr;
        end
    end

    assign min_edge = inc_min & ~min_q;
    assign hr_edge  = inc_hr & ~hr_q;
    // A minute adjust clears the seconds, so a coincident tick is discarded.
    assign sec_step = tick_1hz & run & ~min_edge;

    bcd_mod_counter #(
        .MOD(60)
    ) u_sec (
        .clk      (CLOCK_50),
        .res      (res),
        .inc      (1'b0),
        .carry_in (sec_step),
        .clr      (min_edge),
        .tens     (now.sec_t),
        .ones     (now.sec_o),
        .carry_out(sec_carry)
    );

    bcd_mod_counter #(
        .MOD(60)
    ) u_min (
        .clk      (CLOCK_50),
        .res      (res),
        .inc      (min_edge),
        .carry_in (sec_carry),
        .clr      (1'b0),
        .tens     (now.min_t),
        .ones     (now.min_o),
        .carry_out(min_carry)
    );

    bcd_mod_counter #(
        .MOD(24)
    ) u_hr (
        .clk      (CLOCK_50),
        .res      (res),
        .inc      (hr_edge),
        .carry_in (min_carry),
        .clr      (1'b0),
        .tens     (now.hr_t),
        .ones     (now.hr_o),
        .carry_out(hr_carry_unused)
    );

    assign time_bcd = now;

    // Map scan slot to a position in the HH MM SS frame; MM:SS view starts two places in.
    assign pos = (DIGITS == 4 && !mode) ? idx_q + 3'd2 : idx_q;

    // Pick the BCD digit for the current slot and encode it, blanking a leading hours zero.
    always_comb begin
        case (pos)
            3'd0:    nib = now.hr_t;
            3'd1:    nib = now.hr_o;
            3'd2:    nib = now.min_t;
            3'd3:    nib = now.min_o;
            3'd4:    nib = now.sec_t;
            3'd5:    nib = now.sec_o;
            default: nib = 4'hF;
        endcase
        if (BLANK_LZ && pos == 3'd0 && nib == 4'd0) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg7_of(nib);
        end
    end

    // Scan step: light the current slot and load its pattern together, then advance.
    always_ff @(posedge CLOCK_50 or posedge res) begin
        if (res) begin
            idx_q   <= 3'd0;
            catodes <= SEG_BLANK;
            digits  <= '1;
        end else if (scan_en) begin
            catodes <= seg;
            digits  <= ~(DIGITS'(1) << idx_q);
            idx_q   <= (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_mux_clock_display.sv
// Bench for mux_clock_display: a 4-digit and a 6-digit instance share stimulus and are
// checked against a seconds-of-day reference model with randomized adjust/run/mode input.
module tb_mux_clock_display;

    localparam int unsigned CLK_HZ  = 100;
    localparam int unsigned SCAN_HZ = 25;

    logic clk = 1'b0;
    logic res, run, mode, inc_min, inc_hr;
    logic [6:0]  cat4, cat6;
    logic [3:0]  dig4;
    logic [5:0]  dig6;
    logic        sp4, sp6, tick4, tick6;
    logic [23:0] tb4, tb6;

    always #5 clk = ~clk;

    mux_clock_display #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(4), .BLANK_LZ(1'b1)
    ) dut4 (
        .CLOCK_50(clk), .res(res), .run(run), .mode(mode), .inc_min(inc_min),
        .inc_hr(inc_hr), .catodes(cat4), .digits(dig4), .secondsPoint(sp4),
        .tick_1hz(tick4), .time_bcd(tb4)
    );

    mux_clock_display #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(6), .BLANK_LZ(1'b1)
    ) dut6 (
        .CLOCK_50(clk), .res(res), .run(run), .mode(mode), .inc_min(inc_min),
        .inc_hr(inc_hr), .catodes(cat6), .digits(dig6), .secondsPoint(sp6),
        .tick_1hz(tick6), .time_bcd(tb6)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int n;              // clock edges since reset release
    int hh, mm, ss;
    int scans;          // scan steps since reset release
    bit pmin, phr;
    logic [23:0] e_time;
    logic        e_tick, e_sp;
    logic [3:0]  e_dig4;
    logic [5:0]  e_dig6;
    logic [6:0]  e_cat4, e_cat6;

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0: return 7'b0001000;
            1: return 7'b1101110;
            2: return 7'b0010010;
            3: return 7'b1000010;
            4: return 7'b1100100;
            5: return 7'b1000001;
            6: return 7'b0000001;
            7: return 7'b1101010;
            8: return 7'b0000000;
            9: return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Pattern for position pos of the HH MM SS frame, leading hours zero blanked.
    function automatic logic [6:0] show(input int h, input int m, input int s, input int pos);
        int v;
        case (pos)
            0: v = h / 10;
            1: v = h % 10;
            2: v = m / 10;
            3: v = m % 10;
            4: v = s / 10;
            default: v = s % 10;
        endcase
        if (pos == 0 && v == 0) return 7'b1111111;
        return seg_ref(v);
    endfunction

    function automatic logic [23:0] bcd_of(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_outputs();
        e_time = bcd_of(hh, mm, ss);
        e_tick = (n % CLK_HZ == CLK_HZ - 1);
        e_sp   = (n % CLK_HZ >= CLK_HZ / 2);
    endtask

    task automatic model_reset();
        n = 0; hh = 0; mm = 0; ss = 0; scans = 0; pmin = 0; phr = 0;
        e_dig4 = 4'hF; e_dig6 = 6'h3F; e_cat4 = 7'h7F; e_cat6 = 7'h7F;
        model_outputs();
    endtask

    // One rising clock edge of the reference model, using inputs present at the edge.
    task automatic model_edge();
        bit me, he, tk;
        int lit4, lit6, t;
        tk = (n % CLK_HZ == CLK_HZ - 1);
        if (n % 4 == 3) begin
            lit4 = scans % 4;
            lit6 = scans % 6;
            e_dig4 = ~4'(1 << lit4);
            e_dig6 = ~6'(1 << lit6);
            e_cat4 = show(hh, mm, ss, mode ? lit4 : lit4 + 2);
            e_cat6 = show(hh, mm, ss, lit6);
            scans++;
        end
        me = inc_min && !pmin;
        he = inc_hr && !phr;
        pmin = inc_min;
        phr = inc_hr;
        if (me) begin
            mm = (mm + 1) % 60;
            ss = 0;
        end else if (tk && run) begin
            t = (hh * 3600 + mm * 60 + ss + 1) % 86400;
            hh = t / 3600;
            mm = (t / 60) % 60;
            ss = t % 60;
        end
        if (he) hh = (hh + 1) % 24;
        n++;
        model_outputs();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse(input bit hr);
        if (hr) inc_hr = 1'b1; else inc_min = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        inc_hr = 1'b0;
        inc_min = 1'b0;
        repeat ($urandom_range(1, 3)) step();
    endtask

    task automatic test_reset();
        run = 1'b1;
        repeat ($urandom_range(150, 190)) step();
        #2 res = 1'b1;
        #1;
        if ({cat4, dig4, sp4, tick4, tb4} !== {7'h7F, 4'hF, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_async4 got %h %b %b %b %h", cat4, dig4, sp4, tick4, tb4);
        end
        checks++;
        @(posedge clk);
        #1;
        if ({cat6, dig6, sp6, tick6, tb6} !== {7'h7F, 6'h3F, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_held6 got %h %b %b %b %h", cat6, dig6, sp6, tick6, tb6);
        end
        checks++;
        @(negedge clk);
        res = 1'b0;
        model_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4 && {dig4, cat4, dig6} !== {4'hF, 7'h7F, 6'h3F}) begin
                errors++;
                $display("FAIL reset_dark k=%0d got %b %b %b", k, dig4, cat4, dig6);
            end
            if (k < 4) checks++;
        end
        if ({dig4, cat4} !== {4'b1110, 7'b0001000}) begin
            errors++;
            $display("FAIL first_scan4 got %b %b want 1110 0001000", dig4, cat4);
        end
        checks++;
        if ({dig6, cat6} !== {6'b111110, 7'h7F}) begin
            errors++;
            $display("FAIL first_scan6 got %b %b want 111110 1111111", dig6, cat6);
        end
        checks++;
    endtask

    task automatic test_seconds();
        run = 1'b1;
        mode = 1'b0;
        while (n < 60 * CLK_HZ) begin
            step();
            if ({tb4, tick4, sp4} !== {e_time, e_tick, e_sp}) begin
                errors++;
                $display("FAIL sec_time4 n=%0d got %h %b %b want %h %b %b",
                         n, tb4, tick4, sp4, e_time, e_tick, e_sp);
            end
            checks++;
            if ({dig4, cat4} !== {e_dig4, e_cat4}) begin
                errors++;
                $display("FAIL sec_scan4 n=%0d got %b %b want %b %b",
                         n, dig4, cat4, e_dig4, e_cat4);
            end
            checks++;
            if ({tb6, tick6, sp6, dig6, cat6} !== {e_time, e_tick, e_sp, e_dig6, e_cat6}) begin
                errors++;
                $display("FAIL sec_all6 n=%0d got %h %b %b %b %b want %h %b %b %b %b",
                         n, tb6, tick6, sp6, dig6, cat6, e_time, e_tick, e_sp, e_dig6, e_cat6);
            end
            checks++;
        end
        if (tb4 !== 24'h000100) begin
            errors++;
            $display("FAIL sixty_seconds got %h want 000100", tb4);
        end
        checks++;
    endtask

    task automatic test_wrap();
        run = 1'b0;
        while (hh != 23) pulse(1'b1);
        do pulse(1'b0); while (mm != 59);
        run = 1'b1;
        while (ss != 59 || n % CLK_HZ != CLK_HZ - 1) begin
            step();
            if (tb6 !== e_time) begin
                errors++;
                $display("FAIL wrap_run n=%0d got %h want %h", n, tb6, e_time);
            end
            checks++;
        end
        if (tb4 !== 24'h235959) begin
            errors++;
            $display("FAIL preload_235959 got %h", tb4);
        end
        checks++;
        step();
        if ({tb4, tb6} !== {24'h000000, 24'h000000}) begin
            errors++;
            $display("FAIL day_wrap got %h %h want 000000", tb4, tb6);
        end
        checks++;
    endtask

    task automatic test_coincide();
        run = 1'b0;
        while (hh != 0) pulse(1'b1);
        do pulse(1'b0); while (mm != 5);
        run = 1'b1;
        while (ss != 30 || n % CLK_HZ != CLK_HZ - 1) step();
        if (tb4 !== 24'h000530) begin
            errors++;
            $display("FAIL at_000530 got %h", tb4);
        end
        checks++;
        inc_min = 1'b1;
        step();
        inc_min = 1'b0;
        if ({tb4, tick4} !== {24'h000600, 1'b0}) begin
            errors++;
            $display("FAIL min_with_tick got %h %b want 000600 0", tb4, tick4);
        end
        checks++;
        while (n % CLK_HZ != CLK_HZ - 1) step();
        step();
        if (tb6 !== 24'h000601) begin
            errors++;
            $display("FAIL after_drop got %h want 000601", tb6);
        end
        checks++;
        run = 1'b0;
        while (hh != 22) pulse(1'b1);
        do pulse(1'b0); while (mm != 59);
        run = 1'b1;
        while (ss != 59 || n % CLK_HZ != CLK_HZ - 1) step();
        if (tb4 !== 24'h225959) begin
            errors++;
            $display("FAIL at_225959 got %h", tb4);
        end
        checks++;
        inc_hr = 1'b1;
        step();
        inc_hr = 1'b0;
        if (tb6 !== 24'h000000) begin
            errors++;
            $display("FAIL hr_with_tick got %h want 000000", tb6);
        end
        checks++;
    endtask

    task automatic test_digits6();
        logic [6:0] want [6];
        want = '{7'b1111111, 7'b1101010, 7'b0001000, 7'b0000000, 7'b0001000, 7'b1000000};
        run = 1'b0;
        while (hh != 7) pulse(1'b1);
        do pulse(1'b0); while (mm != 8);
        run = 1'b1;
        while (ss != 9) step();
        run = 1'b0;
        mode = 1'b1;
        while (!(n % 4 == 0 && scans % 6 == 1)) step();
        for (int i = 0; i < 6; i++) begin
            if ({dig6, cat6} !== {~6'(1 << i), want[i]}) begin
                errors++;
                $display("FAIL scan6 slot=%0d got %b %b want %b %b",
                         i, dig6, cat6, ~6'(1 << i), want[i]);
            end
            checks++;
            repeat (4) begin
                step();
                if ($countones(~dig6) != 1 || {dig4, cat4} !== {e_dig4, e_cat4}) begin
                    errors++;
                    $display("FAIL scan_onehot n=%0d got %b %b %b want %b %b",
                             n, dig6, dig4, cat4, e_dig4, e_cat4);
                end
                checks++;
            end
        end
    endtask

    task automatic test_hold_freeze();
        int m_before, exp_ticks, got_ticks;
        logic [23:0] frozen;
        run = 1'b0;
        m_before = mm;
        step();
        inc_min = 1'b1;
        repeat (300) step();
        inc_min = 1'b0;
        step();
        if (tb4[15:8] !== {4'((m_before + 1) % 60 / 10), 4'((m_before + 1) % 10)}) begin
            errors++;
            $display("FAIL hold_one_inc got %h from %0d", tb4[15:8], m_before);
        end
        checks++;
        frozen = e_time;
        exp_ticks = 0;
        got_ticks = 0;
        repeat (250) begin
            step();
            exp_ticks += int'(e_tick);
            got_ticks += int'(tick6);
            if (tb6 !== frozen) begin
                errors++;
                $display("FAIL frozen n=%0d got %h want %h", n, tb6, frozen);
            end
            checks++;
        end
        if (got_ticks != exp_ticks) begin
            errors++;
            $display("FAIL tick_when_stopped got %0d want %0d", got_ticks, exp_ticks);
        end
        checks++;
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 11) == 0) inc_min = ~inc_min;
            if ($urandom_range(0, 11) == 0) inc_hr = ~inc_hr;
            step();
            if ({tb4, tick4, sp4, dig4, cat4} !== {e_time, e_tick, e_sp, e_dig4, e_cat4}) begin
                errors++;
                $display("FAIL rand4 n=%0d got %h %b %b %b %b want %h %b %b %b %b",
                         n, tb4, tick4, sp4, dig4, cat4, e_time, e_tick, e_sp, e_dig4, e_cat4);
            end
            checks++;
            if ({tb6, dig6, cat6} !== {e_time, e_dig6, e_cat6}) begin
                errors++;
                $display("FAIL rand6 n=%0d got %h %b %b want %h %b %b",
                         n, tb6, dig6, cat6, e_time, e_dig6, e_cat6);
            end
            checks++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1;
        run = 1'b0;
        mode = 1'b0;
        inc_min = 1'b0;
        inc_hr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        res = 1'b0;
        test_reset();
        test_seconds();
        test_wrap();
        test_coincide();
        test_digits6();
        test_hold_freeze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
